// File: rtl/lk_window_accumulator_pkg.sv
// Shared types and reset constants for the Lucas-Kanade window accumulator.
package lk_accum_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_e;

   localparam acc_state_e RST_STATE   = IDLE;
   localparam logic       RST_OUT_VAL = 1'b0;
   localparam logic       RST_OUT_OVF = 1'b0;
   localparam logic       RST_BUSY    = 1'b0;

   // Signed-add overflow: both operands share a sign that the raw sum lost.
   function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/lk_window_accumulator_sat_adder.sv
// Single signed adder for the window accumulator.
// Macro LK_ACC_SATURATE_EN: clamp each sum to the signed W-bit range;
// without it the sum wraps modulo 2^W.
module lk_sat_adder
   import lk_accum_pkg::*;
#(
   parameter int W = 15
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] sum
);

   logic signed [W-1:0] raw_sum;

   assign raw_sum = a + b;

`ifdef LK_ACC_SATURATE_EN
   // Clamp toward the sign of the operands when the raw sum overflowed.
   always_comb begin
      if (add_overflow(a[W-1], b[W-1], raw_sum[W-1])) begin
         if (a[W-1]) begin
            sum = {1'b1, {(W-1){1'b0}}};
         end else begin
            sum = {1'b0, {(W-1){1'b1}}};
         end
      end else begin
         sum = raw_sum;
      end
   end
`else
   // Plain two's-complement wrap.
   always_comb begin
      sum = raw_sum;
   end
`endif

endmodule

// File: rtl/lk_window_accumulator.sv
// Sums WIN_LEN consecutive signed products into a window total held behind
// a val/rdy output register. Input is never stalled; a result left unconsumed
// when the next one lands is overwritten and flagged in out_ovf.
// Macro LK_ACC_SATURATE_EN selects saturating instead of wrapping adds.
module lk_window_accumulator
   import lk_accum_pkg::*;
#(
   parameter int P_WIDTH   = 10,
   parameter int WIN_LEN   = 25,
   parameter int ACC_WIDTH = P_WIDTH + 5,
   parameter int CNT_WIDTH = $clog2(WIN_LEN)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_val,
   input  logic signed [P_WIDTH-1:0]   in_p,
   input  logic                        clear,
   output logic                        out_val,
   input  logic                        out_rdy,
   output logic signed [ACC_WIDTH-1:0] out_sum,
   output logic                        out_ovf,
   output logic                        busy
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WIN_LEN - 1);

   acc_state_e                 state_r, state_nxt;
   logic signed [ACC_WIDTH-1:0] acc_r, acc_nxt;
   logic [CNT_WIDTH-1:0]        cnt_r, cnt_nxt;
   logic signed [ACC_WIDTH-1:0] p_ext;
   logic signed [ACC_WIDTH-1:0] add_sum;
   logic                        load;
   logic                        out_val_nxt;
   logic                        out_ovf_nxt;
   logic signed [ACC_WIDTH-1:0] out_sum_nxt;

   assign p_ext = ACC_WIDTH'(in_p);

   // acc_r is zero in IDLE, so the same adder also starts a new window.
   lk_sat_adder #(.W(ACC_WIDTH)) u_adder (
      .a   (acc_r),
      .b   (p_ext),
      .sum (add_sum)
   );

   // Next-state, accumulator and counter update; clear beats in_val.
   always_comb begin
      state_nxt = state_r;
      acc_nxt   = acc_r;
      cnt_nxt   = cnt_r;
      load      = 1'b0;
      if (clear) begin
         state_nxt = IDLE;
         acc_nxt   = '0;
         cnt_nxt   = '0;
      end else if (in_val) begin
         case (state_r)
            IDLE: begin
               state_nxt = ACCUM;
               acc_nxt   = add_sum;
               cnt_nxt   = CNT_WIDTH'(1);
            end
            ACCUM: begin
               if (cnt_r == CNT_LAST) begin
                  state_nxt = IDLE;
                  acc_nxt   = '0;
                  cnt_nxt   = '0;
                  load      = 1'b1;
               end else begin
                  acc_nxt = add_sum;
                  cnt_nxt = cnt_r + CNT_WIDTH'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               acc_nxt   = '0;
               cnt_nxt   = '0;
            end
         endcase
      end else begin
         state_nxt = state_r;
      end
   end

   // Output register: a load wins over the handshake; overwrite of a pending,
   // unaccepted result raises the sticky overflow flag.
   always_comb begin
      out_val_nxt = out_val;
      out_sum_nxt = out_sum;
      out_ovf_nxt = out_ovf;
      if (load) begin
         out_val_nxt = 1'b1;
         out_sum_nxt = add_sum;
         if (out_val && !out_rdy) begin
            out_ovf_nxt = 1'b1;
         end else begin
            out_ovf_nxt = out_ovf;
         end
      end else if (out_val && out_rdy) begin
         out_val_nxt = 1'b0;
      end else begin
         out_val_nxt = out_val;
      end
      if (clear) begin
         out_ovf_nxt = 1'b0;
      end else begin
         out_ovf_nxt = out_ovf_nxt;
      end
   end

   // State, window and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= RST_STATE;
         acc_r   <= '0;
         cnt_r   <= '0;
         out_val <= RST_OUT_VAL;
         out_sum <= '0;
         out_ovf <= RST_OUT_OVF;
         busy    <= RST_BUSY;
      end else begin
         state_r <= state_nxt;
         acc_r   <= acc_nxt;
         cnt_r   <= cnt_nxt;
         out_val <= out_val_nxt;
         out_sum <= out_sum_nxt;
         out_ovf <= out_ovf_nxt;
         busy    <= (state_nxt == ACCUM);
      end
   end

endmodule

// File: tb/tb_lk_window_accumulator.sv
// Scoreboard bench for lk_window_accumulator (WIN_LEN=4, P_WIDTH=10, ACC_WIDTH=10).
// Honours LK_ACC_SATURATE_EN in its reference model.
module tb_lk_window_accumulator;

   localparam int PW = 10;
   localparam int WL = 4;
   localparam int AW = 10;
   localparam int MAXV = (2 ** (AW - 1)) - 1;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 in_val = 1'b0;
   logic signed [PW-1:0] in_p = '0;
   logic                 clear = 1'b0;
   logic                 out_rdy = 1'b0;
   logic                 out_val;
   logic signed [AW-1:0] out_sum;
   logic                 out_ovf;
   logic                 busy;

   int checks = 0;
   int errors = 0;

   logic signed [AW-1:0] exp_q[$];
   logic signed [AW-1:0] m_acc = '0;
   int                   m_cnt = 0;
   logic                 m_val = 1'b0;
   logic                 m_ovf = 1'b0;

   lk_window_accumulator #(
      .P_WIDTH   (PW),
      .WIN_LEN   (WL),
      .ACC_WIDTH (AW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .in_val  (in_val),
      .in_p    (in_p),
      .clear   (clear),
      .out_val (out_val),
      .out_rdy (out_rdy),
      .out_sum (out_sum),
      .out_ovf (out_ovf),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [AW-1:0] m_add(input logic signed [AW-1:0] a, input int p);
      int s;
      s = int'(a) + p;
`ifdef LK_ACC_SATURATE_EN
      if (s > MAXV) s = MAXV;
      if (s < -MAXV - 1) s = -MAXV - 1;
`endif
      return AW'(s);
   endfunction

   // One clock cycle: drive at the falling edge, update model, check at next falling edge.
   task automatic step(input logic v, input int p, input logic c, input logic r, input string tag);
      logic fin;
      logic signed [AW-1:0] e;
      fin = 1'b0;
      in_val = v;
      in_p = PW'(p);
      clear = c;
      out_rdy = r;
      if (c) begin
         m_acc = '0;
         m_cnt = 0;
      end else if (v) begin
         m_acc = m_add(m_acc, p);
         m_cnt++;
         if (m_cnt == WL) begin
            exp_q.push_back(m_acc);
            m_acc = '0;
            m_cnt = 0;
            fin = 1'b1;
         end
      end
      if (fin) begin
         if (m_val && !r) m_ovf = 1'b1;
         m_val = 1'b1;
      end else if (m_val && r) begin
         m_val = 1'b0;
      end
      if (c) m_ovf = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (fin) begin
         e = exp_q.pop_front();
         check_val({tag, ".sum"}, out_sum, e);
      end
      check_val({tag, ".val"}, out_val, m_val);
      check_val({tag, ".ovf"}, out_ovf, m_ovf);
      check_val({tag, ".busy"}, busy, (m_cnt != 0));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, ".val"}, out_val, 0);
      check_val({tag, ".sum"}, out_sum, 0);
      check_val({tag, ".ovf"}, out_ovf, 0);
      check_val({tag, ".busy"}, busy, 0);
   endtask

   initial begin
      int vals[4];
      #2;
      check_reset_outputs("rst0");
      @(negedge clk);
      reset = 1'b1;

      // Basic window, result held until accepted.
      vals = '{3, -5, 7, 100};
      foreach (vals[i]) step(1'b1, vals[i], 1'b0, 1'b0, "basic");
      check_val("basic.const", out_sum, 105);
      step(1'b0, 0, 1'b0, 1'b0, "hold");
      step(1'b0, 0, 1'b0, 1'b0, "hold");
      step(1'b0, 0, 1'b0, 1'b1, "accept");

      // Gapped input, two windows of four ones.
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 2)) step(1'b0, 0, 1'b0, 1'b1, "gap");
         step(1'b1, 1, 1'b0, 1'b1, "gapped");
      end

      // Back-to-back windows with no bubble: -3..0 then 1..4.
      for (int i = 0; i < 8; i++) step(1'b1, i - 3, 1'b0, 1'b1, "b2b");

      // Overflow: two windows land while the consumer stalls.
      for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b0, "ovfA");
      for (int i = 0; i < 4; i++) step(1'b1, 2, 1'b0, 1'b0, "ovfB");
      check_val("ovf.const_sum", out_sum, 8);
      check_val("ovf.const_flag", out_ovf, 1);
      step(1'b0, 0, 1'b0, 1'b1, "ovf_accept");
      step(1'b0, 0, 1'b1, 1'b0, "ovf_clear");

      // Load coincident with handshake: no overflow.
      for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b0, "hsA");
      for (int i = 0; i < 3; i++) step(1'b1, 2, 1'b0, 1'b0, "hsB");
      step(1'b1, 2, 1'b0, 1'b1, "hsB_last");
      check_val("hs.const_ovf", out_ovf, 0);
      step(1'b0, 0, 1'b0, 1'b1, "hs_accept");

      // Clear on the third sample discards the window and that product.
      step(1'b1, 9, 1'b0, 1'b1, "clr");
      step(1'b1, 9, 1'b0, 1'b1, "clr");
      step(1'b1, 50, 1'b1, 1'b1, "clr_hit");
      for (int i = 0; i < 4; i++) step(1'b1, 2, 1'b0, 1'b1, "clr_after");
      check_val("clr.const", out_sum, 8);

      // Saturation versus wrap with 511 x4.
      for (int i = 0; i < 4; i++) step(1'b1, 511, 1'b0, 1'b1, "sat");
`ifdef LK_ACC_SATURATE_EN
      check_val("sat.const", out_sum, 511);
`else
      check_val("wrap.const", out_sum, -4);
`endif

      // Asynchronous reset mid-window with a result pending.
      for (int i = 0; i < 4; i++) step(1'b1, 6, 1'b0, 1'b0, "pre_rst");
      step(1'b1, 5, 1'b0, 1'b0, "mid");
      step(1'b1, 5, 1'b0, 1'b0, "mid");
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      m_acc = '0;
      m_cnt = 0;
      m_val = 1'b0;
      m_ovf = 1'b0;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, -1, 1'b0, 1'b1, "post_rst");
      check_val("post_rst.const", out_sum, -4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
